// File: rtl/poly_voice_engine.sv
// poly_voice_engine: polyphonic voice engine with NVOICES dynamically allocated voices.
// One voice is scanned per cycle, so a frame is NVOICES cycles long. Each scan presents the
// voice phase to a shared external sine approximator and advances the phase of an active voice.
// A tag pipeline SINE_LAT deep carries {voice, active} alongside the approximator latency, so
// each returning amplitude is written to its voice and added into the frame mix.
// Note events (on/off) are taken over valid/ready and applied one cycle after acceptance.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   note_valid/note_ready  note event handshake
//   note_on, note_key      event type (1 = on) and key number
//   note_inc               phase increment for note-on
//   sine_angle             registered angle to the shared sine approximator
//   sine_amp               approximator result, SINE_LAT cycles after the scan that chose it
//   voice_amp              per-voice amplitude, voice v at [v*AMP_W +: AMP_W]
//   mix, mix_valid         frame sum of all voice amplitudes and its one-cycle strobe
//   active                 voice-active bitmask
module poly_voice_engine #(
    parameter int unsigned NVOICES  = 8,
    parameter int unsigned PHASE_W  = 24,
    parameter int unsigned AMP_W    = 16,
    parameter int unsigned SINE_LAT = 3,
    parameter int unsigned KEY_W    = 7
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       note_valid,
    output logic                                       note_ready,
    input  logic                                       note_on,
    input  logic [KEY_W-1:0]                           note_key,
    input  logic [PHASE_W-1:0]                         note_inc,
    output logic [PHASE_W-1:0]                         sine_angle,
    input  logic signed [AMP_W-1:0]                    sine_amp,
    output logic [NVOICES*AMP_W-1:0]                   voice_amp,
    output logic signed [AMP_W+$clog2(NVOICES)-1:0]    mix,
    output logic                                       mix_valid,
    output logic [NVOICES-1:0]                         active
);

    localparam int unsigned IDX_W = $clog2(NVOICES);
    localparam int unsigned MIX_W = AMP_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_V = IDX_W'(NVOICES - 1);

    typedef enum logic [0:0] {StIdle, StApply} state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [IDX_W-1:0]          steal_q, steal_d;
    logic [PHASE_W-1:0]        phase_q [NVOICES];
    logic [PHASE_W-1:0]        phase_d [NVOICES];
    logic [PHASE_W-1:0]        inc_q [NVOICES];
    logic [PHASE_W-1:0]        inc_d [NVOICES];
    logic [KEY_W-1:0]          key_q [NVOICES];
    logic [KEY_W-1:0]          key_d [NVOICES];
    logic [NVOICES-1:0]        active_q, active_d;
    logic [PHASE_W-1:0]        angle_q, angle_d;
    logic [SINE_LAT-1:0]       tag_vld_q, tag_vld_d;
    logic [SINE_LAT-1:0]       tag_act_q, tag_act_d;
    logic [IDX_W-1:0]          tag_idx_q [SINE_LAT];
    logic [IDX_W-1:0]          tag_idx_d [SINE_LAT];
    logic [AMP_W-1:0]          amp_q [NVOICES];
    logic [AMP_W-1:0]          amp_d [NVOICES];
    logic signed [MIX_W-1:0]   mix_q, mix_d, acc_q, acc_d;
    logic                      mv_q, mv_d;
    logic                      ev_on_q, ev_on_d;
    logic [KEY_W-1:0]          ev_key_q, ev_key_d;
    logic [PHASE_W-1:0]        ev_inc_q, ev_inc_d;

    logic                      hit, free;
    logic [IDX_W-1:0]          hit_idx, free_idx, tgt;
    logic signed [AMP_W-1:0]   term;
    logic [IDX_W-1:0]          out_idx;

    // Key match among active voices, and lowest-index inactive voice.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = 0; i < int'(NVOICES); i++) begin
            if (active_q[i] && (key_q[i] == ev_key_q)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
        for (int i = int'(NVOICES) - 1; i >= 0; i--) begin
            if (!active_q[i]) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        steal_d   = steal_q;
        phase_d   = phase_q;
        inc_d     = inc_q;
        key_d     = key_q;
        active_d  = active_q;
        ev_on_d   = ev_on_q;
        ev_key_d  = ev_key_q;
        ev_inc_d  = ev_inc_q;
        amp_d     = amp_q;
        mix_d     = mix_q;
        acc_d     = acc_q;
        mv_d      = 1'b0;
        tgt       = '0;
        note_ready = 1'b0;

        // Scan one voice per cycle.
        ptr_d   = (ptr_q == LAST_V) ? '0 : ptr_q + 1'b1;
        angle_d = phase_q[ptr_q];
        if (active_q[ptr_q]) begin
            phase_d[ptr_q] = phase_q[ptr_q] + inc_q[ptr_q];
        end
        tag_vld_d    = tag_vld_q;
        tag_act_d    = tag_act_q;
        tag_idx_d    = tag_idx_q;
        tag_vld_d[0] = 1'b1;
        tag_act_d[0] = active_q[ptr_q];
        tag_idx_d[0] = ptr_q;
        for (int i = 1; i < int'(SINE_LAT); i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_act_d[i] = tag_act_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end

        // Note FSM; its writes come after the scan so they win on a collision.
        unique case (state_q)
            StIdle: begin
                note_ready = 1'b1;
                if (note_valid) begin
                    ev_on_d  = note_on;
                    ev_key_d = note_key;
                    ev_inc_d = note_inc;
                    state_d  = StApply;
                end
            end
            StApply: begin
                state_d = StIdle;
                if (ev_on_q) begin
                    if (hit) begin
                        tgt = hit_idx;
                    end else if (free) begin
                        tgt = free_idx;
                    end else begin
                        tgt     = steal_q;
                        steal_d = (steal_q == LAST_V) ? '0 : steal_q + 1'b1;
                    end
                    key_d[tgt]    = ev_key_q;
                    inc_d[tgt]    = ev_inc_q;
                    phase_d[tgt]  = '0;
                    active_d[tgt] = 1'b1;
                end else if (hit) begin
                    active_d[hit_idx] = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Returning amplitude pairs with the oldest tag.
        out_idx = tag_idx_q[SINE_LAT-1];
        term    = tag_act_q[SINE_LAT-1] ? sine_amp : '0;
        if (tag_vld_q[SINE_LAT-1]) begin
            amp_d[out_idx] = term;
            if (out_idx == LAST_V) begin
                mix_d = acc_q + MIX_W'(term);
                acc_d = '0;
                mv_d  = 1'b1;
            end else begin
                acc_d = acc_q + MIX_W'(term);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            steal_q   <= '0;
            active_q  <= '0;
            angle_q   <= '0;
            tag_vld_q <= '0;
            tag_act_q <= '0;
            mix_q     <= '0;
            acc_q     <= '0;
            mv_q      <= 1'b0;
            ev_on_q   <= 1'b0;
            ev_key_q  <= '0;
            ev_inc_q  <= '0;
            for (int v = 0; v < int'(NVOICES); v++) begin
                phase_q[v] <= '0;
                inc_q[v]   <= '0;
                key_q[v]   <= '0;
                amp_q[v]   <= '0;
            end
            for (int i = 0; i < int'(SINE_LAT); i++) begin
                tag_idx_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            steal_q   <= steal_d;
            active_q  <= active_d;
            angle_q   <= angle_d;
            tag_vld_q <= tag_vld_d;
            tag_act_q <= tag_act_d;
            tag_idx_q <= tag_idx_d;
            mix_q     <= mix_d;
            acc_q     <= acc_d;
            mv_q      <= mv_d;
            ev_on_q   <= ev_on_d;
            ev_key_q  <= ev_key_d;
            ev_inc_q  <= ev_inc_d;
            phase_q   <= phase_d;
            inc_q     <= inc_d;
            key_q     <= key_d;
            amp_q     <= amp_d;
        end
    end

    always_comb begin
        voice_amp = '0;
        for (int v = 0; v < int'(NVOICES); v++) begin
            voice_amp[v*AMP_W +: AMP_W] = amp_q[v];
        end
    end

    assign sine_angle = angle_q;
    assign mix        = mix_q;
    assign mix_valid  = mv_q;
    assign active     = active_q;

endmodule

// File: tb/tb_poly_voice_engine.sv
// Bench for poly_voice_engine (4 voices, sine latency 3). The reference model tracks voice
// state with plain arrays and keeps a queue of amplitudes that are due back at a given cycle.
module tb_poly_voice_engine;

    localparam int NV = 4;
    localparam int PW = 24;
    localparam int AW = 16;
    localparam int SL = 3;
    localparam int KW = 7;
    localparam int MW = 18;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 note_valid = 1'b0;
    logic                 note_on = 1'b0;
    logic [KW-1:0]        note_key = '0;
    logic [PW-1:0]        note_inc = '0;
    logic                 note_ready;
    logic [PW-1:0]        sine_angle;
    logic signed [AW-1:0] sine_amp;
    logic [NV*AW-1:0]     voice_amp;
    logic signed [MW-1:0] mix;
    logic                 mix_valid;
    logic [NV-1:0]        active;

    poly_voice_engine #(
        .NVOICES (NV),
        .PHASE_W (PW),
        .AMP_W   (AW),
        .SINE_LAT(SL),
        .KEY_W   (KW)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note_on   (note_on),
        .note_key  (note_key),
        .note_inc  (note_inc),
        .sine_angle(sine_angle),
        .sine_amp  (sine_amp),
        .voice_amp (voice_amp),
        .mix       (mix),
        .mix_valid (mix_valid),
        .active    (active)
    );

    always #5 clk = ~clk;

    // External approximator: the registered angle is the first latency stage, so SL-1 more.
    logic [PW-1:0] sdly [SL-1];
    always @(posedge clk) begin
        sdly[0] <= sine_angle;
        for (int i = 1; i < SL - 1; i++) sdly[i] <= sdly[i-1];
    end
    assign sine_amp = sdly[SL-2][PW-1 -: AW];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int                   due;
        int                   v;
        logic signed [AW-1:0] term;
    } ent_t;

    ent_t                 q[$];
    int                   cyc = 0;
    int                   m_ptr, m_steal;
    logic [PW-1:0]        m_phase [NV];
    logic [PW-1:0]        m_inc [NV];
    logic [KW-1:0]        m_key [NV];
    logic [NV-1:0]        m_active;
    bit                   m_pend, m_ev_on, last_acc;
    logic [KW-1:0]        m_ev_key;
    logic [PW-1:0]        m_ev_inc;
    logic [AW-1:0]        e_amp [NV];
    int                   e_acc;
    logic signed [MW-1:0] e_mix;
    logic                 e_mv;
    logic [PW-1:0]        e_angle;

    task automatic model_reset();
        q.delete();
        m_ptr = 0; m_steal = 0; m_active = '0; m_pend = 0; last_acc = 0;
        m_ev_on = 0; m_ev_key = '0; m_ev_inc = '0;
        e_acc = 0; e_mix = '0; e_mv = 1'b0; e_angle = '0;
        for (int v = 0; v < NV; v++) begin
            m_phase[v] = '0; m_inc[v] = '0; m_key[v] = '0; e_amp[v] = '0;
        end
    endtask

    task automatic model_apply();
        int found;
        found = -1;
        for (int v = 0; v < NV; v++)
            if (m_active[v] && m_key[v] == m_ev_key) found = v;
        if (m_ev_on) begin
            if (found < 0) begin
                for (int v = NV - 1; v >= 0; v--) if (!m_active[v]) found = v;
            end
            if (found < 0) begin
                found = m_steal;
                m_steal = (m_steal + 1) % NV;
            end
            m_key[found] = m_ev_key;
            m_inc[found] = m_ev_inc;
            m_phase[found] = '0;
            m_active[found] = 1'b1;
        end else if (found >= 0) begin
            m_active[found] = 1'b0;
        end
    endtask

    // Advance the model by one clock edge, using the inputs the DUT just sampled.
    task automatic model_edge();
        ent_t e;
        last_acc = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        e_mv = 1'b0;
        while (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            e_amp[e.v] = e.term;
            if (e.v == NV - 1) begin
                e_mix = MW'(e_acc + int'(e.term));
                e_acc = 0;
                e_mv = 1'b1;
            end else begin
                e_acc += int'(e.term);
            end
        end
        e_angle = m_phase[m_ptr];
        e.due = cyc + SL;
        e.v = m_ptr;
        e.term = m_active[m_ptr] ? m_phase[m_ptr][PW-1 -: AW] : '0;
        q.push_back(e);
        if (m_active[m_ptr]) m_phase[m_ptr] = m_phase[m_ptr] + m_inc[m_ptr];
        if (m_pend) begin
            model_apply();
            m_pend = 0;
        end else if (note_valid) begin
            m_pend = 1; last_acc = 1;
            m_ev_on = note_on; m_ev_key = note_key; m_ev_inc = note_inc;
        end
        m_ptr = (m_ptr + 1) % NV;
        cyc++;
    endtask

    task automatic compare_all();
        logic [NV*AW-1:0] ea;
        for (int v = 0; v < NV; v++) ea[v*AW +: AW] = e_amp[v];
        check("active", active, m_active);
        check("note_ready", note_ready, !m_pend);
        check("mix_valid", mix_valid, e_mv);
        check("sine_angle", sine_angle, e_angle);
        check("voice_amp", voice_amp, ea);
        check("mix", mix, e_mix);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic send_note(input bit on, input int key, input logic [PW-1:0] inc);
        bit done;
        done = 0;
        note_valid = 1'b1; note_on = on; note_key = KW'(key); note_inc = inc;
        for (int i = 0; i < 8 && !done; i++) begin
            step();
            done = last_acc;
        end
        note_valid = 1'b0;
        check("note_accept", done, 1);
    endtask

    // Async reset between edges, then measure latency of the first frame strobe.
    task automatic do_reset();
        int first;
        first = -1;
        note_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        step();
        step();
        #3;
        rst_n = 1'b1;
        for (int n = 1; n <= 20 && first < 0; n++) begin
            step();
            if (mix_valid) first = n;
        end
        check("first_mix_valid", first, 7);
    endtask

    initial begin
        model_reset();
        do_reset();
        run(8);

        send_note(1, 60, 24'h010000);
        run(16);

        send_note(1, 61, 24'h008000);
        send_note(1, 62, 24'h012345);
        send_note(1, 63, 24'h001000);
        run(4);
        check("all_active", active, 4'b1111);
        send_note(1, 70, 24'h030000);
        run(12);
        send_note(1, 71, 24'h004000);
        run(12);

        send_note(0, 99, '0);
        run(4);
        check("off_absent", active, 4'b1111);
        send_note(0, 62, '0);
        run(12);
        check("off_62", active, 4'b1011);
        send_note(1, 63, 24'h020000);
        run(12);
        check("retrigger", active, 4'b1011);

        for (int i = 0; i < 800; i++) begin
            if (!note_valid && $urandom_range(0, 2) == 0) begin
                note_valid = 1'b1;
                note_on = ($urandom_range(0, 4) < 3);
                note_key = KW'($urandom_range(60, 67));
                note_inc = PW'($urandom_range(0, 24'h3ffff));
            end
            step();
            if (last_acc) note_valid = 1'b0;
        end
        note_valid = 1'b0;
        run(4);

        do_reset();
        send_note(1, 10, 24'h011000);
        send_note(1, 11, 24'h022000);
        send_note(1, 12, 24'h033000);
        run(9);
        do_reset();
        run(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
